// File: rtl/inner_loop_pkg.sv
// Shared types, defaults and width helpers for the inner-loop sequencer.
// Pure definitions: no logic, no latency, no flow control.
// The per-run configuration is kept as one packed struct so it latches as a unit.
package inner_loop_pkg;

   localparam int unsigned DEF_FIL_SIZE_X      = 3;
   localparam int unsigned DEF_FIL_SIZE_MAX    = 9;
   localparam int unsigned DEF_OUT_SIZE_X      = 4;
   localparam int unsigned DEF_PREFIX_SUM_SIZE = 32;
   localparam int unsigned DEF_RD_DAT_CYC_NUM  = 32;
   localparam int unsigned DEF_OUTPUT_BUF_NUM  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } inner_loop_state_e;

   typedef struct packed {
      logic [31:0] ifm_y;
      logic [31:0] fil_y_last;
      logic [31:0] fil_x_step;
      logic [31:0] sub_channel_size;
      logic [31:0] stride_x;
   } inner_loop_cfg_t;

   // Index width for a table of n entries; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inner_loop_addr_gen.sv
// Maps one (filter-row, output-x, data offset) position to the sub-chunk command fields.
// Purely combinational, zero latency; no flow control of its own.
// All arithmetic is 32-bit unsigned and wraps when truncated to the port widths.
module inner_loop_addr_gen
   import inner_loop_pkg::*;
#(
   parameter int unsigned FIL_SIZE_X      = DEF_FIL_SIZE_X,
   parameter int unsigned FIL_SIZE_MAX    = DEF_FIL_SIZE_MAX,
   parameter int unsigned OUT_SIZE_X      = DEF_OUT_SIZE_X,
   parameter int unsigned PREFIX_SUM_SIZE = DEF_PREFIX_SUM_SIZE,
   parameter int unsigned RD_DAT_CYC_NUM  = DEF_RD_DAT_CYC_NUM,
   parameter int unsigned OUTPUT_BUF_NUM  = DEF_OUTPUT_BUF_NUM
) (
   input  logic [31:0]                          y_i,
   input  logic [31:0]                          x_i,
   input  logic [31:0]                          dat_i,
   input  logic [31:0]                          ifm_y_i,
   input  logic [31:0]                          fil_x_step_i,
   input  logic [31:0]                          sub_channel_size_i,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     fil_first_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     fil_last_o,
   output logic [idx_w(FIL_SIZE_MAX)-1:0]       nz_first_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     ifm_first_o,
   output logic [idx_w(PREFIX_SUM_SIZE)-1:0]    shift_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     next_o,
   output logic [idx_w(OUTPUT_BUF_NUM)-1:0]     acc_o
);

   localparam int unsigned RW = idx_w(RD_DAT_CYC_NUM);
   localparam int unsigned NW = idx_w(FIL_SIZE_MAX);
   localparam int unsigned PW = idx_w(PREFIX_SUM_SIZE);
   localparam int unsigned AW = idx_w(OUTPUT_BUF_NUM);
   localparam int unsigned SH = $clog2(PREFIX_SUM_SIZE);

   logic [31:0] fil_base;

   assign fil_base    = y_i * 32'(FIL_SIZE_X);
   assign fil_first_o = RW'(fil_base);
   assign fil_last_o  = RW'(fil_base + fil_x_step_i - 32'd1);
   assign nz_first_o  = NW'(y_i);
   assign ifm_first_o = RW'(dat_i >> SH);
   assign shift_o     = PW'(dat_i & 32'(PREFIX_SUM_SIZE - 1));
   // The last output-x of a row has no following word to prefetch.
   assign next_o      = (x_i == 32'(OUT_SIZE_X - 1)) ? '0 : RW'(sub_channel_size_i - 32'd1);
   assign acc_o       = AW'(((ifm_y_i - y_i) * 32'(OUT_SIZE_X) + x_i) % 32'(OUTPUT_BUF_NUM));

endmodule

// File: rtl/inner_loop_sequencer.sv
// Walks filter rows x output-x for one ifm row, one sub-chunk command per pair (optional abort: INNER_LOOP_ABORT_EN).
// Latency: command 1 cycle after start or after each sub_chunk_end; finish 1 cycle after the last end.
// Backpressure: holds each command stable in WAIT until sub_chunk_end_i; start is ignored while busy.
module inner_loop_sequencer
   import inner_loop_pkg::*;
#(
   parameter int unsigned FIL_SIZE_X      = DEF_FIL_SIZE_X,
   parameter int unsigned FIL_SIZE_MAX    = DEF_FIL_SIZE_MAX,
   parameter int unsigned OUT_SIZE_X      = DEF_OUT_SIZE_X,
   parameter int unsigned PREFIX_SUM_SIZE = DEF_PREFIX_SUM_SIZE,
   parameter int unsigned RD_DAT_CYC_NUM  = DEF_RD_DAT_CYC_NUM,
   parameter int unsigned OUTPUT_BUF_NUM  = DEF_OUTPUT_BUF_NUM
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 inner_loop_start_i,
   input  logic [31:0]                          ifm_y_i,
   input  logic [31:0]                          fil_y_first_i,
   input  logic [31:0]                          fil_y_last_i,
   input  logic [31:0]                          fil_x_step_i,
   input  logic [31:0]                          sub_channel_size_i,
   input  logic [31:0]                          stride_x_i,
`ifdef INNER_LOOP_ABORT_EN
   input  logic                                 abort_i,
`endif
   input  logic                                 sub_chunk_end_i,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     rd_fil_sparsemap_first_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     rd_fil_sparsemap_last_o,
   output logic [idx_w(FIL_SIZE_MAX)-1:0]       rd_fil_nonzero_dat_first_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     rd_ifm_sparsemap_first_o,
   output logic [idx_w(PREFIX_SUM_SIZE)-1:0]    sparsemap_shift_left_o,
   output logic [idx_w(RD_DAT_CYC_NUM)-1:0]     rd_ifm_sparsemap_next_o,
   output logic [idx_w(OUTPUT_BUF_NUM)-1:0]     acc_buf_sel_o,
   output logic                                 sub_chunk_start_o,
   output logic                                 inner_loop_finish_o,
   output logic                                 busy_o
);

   localparam int unsigned RW = idx_w(RD_DAT_CYC_NUM);
   localparam int unsigned NW = idx_w(FIL_SIZE_MAX);
   localparam int unsigned PW = idx_w(PREFIX_SUM_SIZE);
   localparam int unsigned AW = idx_w(OUTPUT_BUF_NUM);

   inner_loop_state_e state_q, state_d;
   inner_loop_cfg_t   cfg_q, cfg_d;
   logic [31:0]       y_q, y_d, x_q, x_d, dat_q, dat_d;
   logic              abort_w, clear_out;

   logic [RW-1:0] fil_first_q, fil_first_d, fil_last_q, fil_last_d;
   logic [NW-1:0] nz_first_q, nz_first_d;
   logic [RW-1:0] ifm_first_q, ifm_first_d, ifm_next_q, ifm_next_d;
   logic [PW-1:0] shift_q, shift_d;
   logic [AW-1:0] acc_q, acc_d;
   logic          start_q, start_d, finish_q, finish_d;

   logic [RW-1:0] gen_fil_first, gen_fil_last, gen_ifm_first, gen_next;
   logic [NW-1:0] gen_nz_first;
   logic [PW-1:0] gen_shift;
   logic [AW-1:0] gen_acc;

`ifdef INNER_LOOP_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      y_d       = y_q;
      x_d       = x_q;
      dat_d     = dat_q;
      clear_out = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (inner_loop_start_i) begin
               cfg_d.ifm_y            = ifm_y_i;
               cfg_d.fil_y_last       = fil_y_last_i;
               cfg_d.fil_x_step       = fil_x_step_i;
               cfg_d.sub_channel_size = sub_channel_size_i;
               cfg_d.stride_x         = (stride_x_i == 32'd0) ? 32'd1 : stride_x_i;
               y_d     = fil_y_first_i;
               x_d     = '0;
               dat_d   = '0;
               state_d = (fil_y_first_i > fil_y_last_i) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (sub_chunk_end_i) begin
               if (x_q == 32'(OUT_SIZE_X - 1)) begin
                  if (y_q == cfg_q.fil_y_last) begin
                     state_d = ST_DONE;
                  end else begin
                     y_d     = y_q + 32'd1;
                     x_d     = '0;
                     dat_d   = '0;
                     state_d = ST_ISSUE;
                  end
               end else begin
                  x_d     = x_q + 32'd1;
                  dat_d   = dat_q + cfg_q.sub_channel_size * cfg_q.stride_x;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over a coincident end and suppresses the finish pulse.
      if (abort_w && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         clear_out = 1'b1;
      end
   end

   // Generator looks at the next position so the command registers load with the state change.
   inner_loop_addr_gen #(
      .FIL_SIZE_X      (FIL_SIZE_X),
      .FIL_SIZE_MAX    (FIL_SIZE_MAX),
      .OUT_SIZE_X      (OUT_SIZE_X),
      .PREFIX_SUM_SIZE (PREFIX_SUM_SIZE),
      .RD_DAT_CYC_NUM  (RD_DAT_CYC_NUM),
      .OUTPUT_BUF_NUM  (OUTPUT_BUF_NUM)
   ) u_addr_gen (
      .y_i                (y_d),
      .x_i                (x_d),
      .dat_i              (dat_d),
      .ifm_y_i            (cfg_d.ifm_y),
      .fil_x_step_i       (cfg_d.fil_x_step),
      .sub_channel_size_i (cfg_d.sub_channel_size),
      .fil_first_o        (gen_fil_first),
      .fil_last_o         (gen_fil_last),
      .nz_first_o         (gen_nz_first),
      .ifm_first_o        (gen_ifm_first),
      .shift_o            (gen_shift),
      .next_o             (gen_next),
      .acc_o              (gen_acc)
   );

   always_comb begin
      fil_first_d = fil_first_q;
      fil_last_d  = fil_last_q;
      nz_first_d  = nz_first_q;
      ifm_first_d = ifm_first_q;
      shift_d     = shift_q;
      ifm_next_d  = ifm_next_q;
      acc_d       = acc_q;
      if (clear_out) begin
         fil_first_d = '0;
         fil_last_d  = '0;
         nz_first_d  = '0;
         ifm_first_d = '0;
         shift_d     = '0;
         ifm_next_d  = '0;
         acc_d       = '0;
      end else if (state_d == ST_ISSUE) begin
         fil_first_d = gen_fil_first;
         fil_last_d  = gen_fil_last;
         nz_first_d  = gen_nz_first;
         ifm_first_d = gen_ifm_first;
         shift_d     = gen_shift;
         ifm_next_d  = gen_next;
         acc_d       = gen_acc;
      end
      start_d  = (state_d == ST_ISSUE);
      finish_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cfg_q       <= '0;
         y_q         <= '0;
         x_q         <= '0;
         dat_q       <= '0;
         fil_first_q <= '0;
         fil_last_q  <= '0;
         nz_first_q  <= '0;
         ifm_first_q <= '0;
         shift_q     <= '0;
         ifm_next_q  <= '0;
         acc_q       <= '0;
         start_q     <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         y_q         <= y_d;
         x_q         <= x_d;
         dat_q       <= dat_d;
         fil_first_q <= fil_first_d;
         fil_last_q  <= fil_last_d;
         nz_first_q  <= nz_first_d;
         ifm_first_q <= ifm_first_d;
         shift_q     <= shift_d;
         ifm_next_q  <= ifm_next_d;
         acc_q       <= acc_d;
         start_q     <= start_d;
         finish_q    <= finish_d;
      end
   end

   assign rd_fil_sparsemap_first_o   = fil_first_q;
   assign rd_fil_sparsemap_last_o    = fil_last_q;
   assign rd_fil_nonzero_dat_first_o = nz_first_q;
   assign rd_ifm_sparsemap_first_o   = ifm_first_q;
   assign sparsemap_shift_left_o     = shift_q;
   assign rd_ifm_sparsemap_next_o    = ifm_next_q;
   assign acc_buf_sel_o              = acc_q;
   assign sub_chunk_start_o          = start_q;
   assign inner_loop_finish_o        = finish_q;
   assign busy_o                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inner_loop_sequencer.sv
// Directed bench for inner_loop_sequencer at default parameters.
module tb_inner_loop_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] ifm_y, fy_first, fy_last, step, subch, stride;
   logic        sc_end;
   logic        abort;
   logic [4:0]  o_fil_first, o_fil_last, o_ifm_first, o_shift, o_next;
   logic [3:0]  o_nz, o_acc;
   logic        o_start, o_finish, o_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cmd_cnt = 0;
   int fin_cnt = 0;

   inner_loop_sequencer dut (
      .clk_i                      (clk),
      .rst_ni                     (rst_n),
      .inner_loop_start_i         (start),
      .ifm_y_i                    (ifm_y),
      .fil_y_first_i              (fy_first),
      .fil_y_last_i               (fy_last),
      .fil_x_step_i               (step),
      .sub_channel_size_i         (subch),
      .stride_x_i                 (stride),
`ifdef INNER_LOOP_ABORT_EN
      .abort_i                    (abort),
`endif
      .sub_chunk_end_i            (sc_end),
      .rd_fil_sparsemap_first_o   (o_fil_first),
      .rd_fil_sparsemap_last_o    (o_fil_last),
      .rd_fil_nonzero_dat_first_o (o_nz),
      .rd_ifm_sparsemap_first_o   (o_ifm_first),
      .sparsemap_shift_left_o     (o_shift),
      .rd_ifm_sparsemap_next_o    (o_next),
      .acc_buf_sel_o              (o_acc),
      .sub_chunk_start_o          (o_start),
      .inner_loop_finish_o        (o_finish),
      .busy_o                     (o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (o_start === 1'b1) cmd_cnt++;
      if (o_finish === 1'b1) fin_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int iy, input int f0, input int f1, input int st, input int sc, input int sx);
      ifm_y = iy; fy_first = f0; fy_last = f1; step = st; subch = sc; stride = sx;
   endtask

   task automatic test_reset;
      logic [32:0] got;
      rst_n = 1'b1; start = 0; sc_end = 0; abort = 0;
      set_cfg(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #2;
      got = {o_fil_first, o_fil_last, o_nz, o_ifm_first, o_shift, o_next, o_acc};
      n_cmp++;
      if (got !== 33'd0 || {o_start, o_finish, o_busy} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_state: fields=%h flags=%b, required 0/000", got, {o_start, o_finish, o_busy});
      end
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_main_run;
      logic [32:0] got, exp;
      int c0, dat;
      c0 = cmd_cnt;
      set_cfg(2, 0, 2, 3, 8, 1);
      start = 1; tick; start = 0;
      for (int y = 0; y < 3; y++) begin
         for (int x = 0; x < 4; x++) begin
            dat = x * 8;
            exp = {5'(y * 3), 5'(y * 3 + 2), 4'(y), 5'(dat >> 5), 5'(dat & 31),
                   (x == 3) ? 5'd0 : 5'd7, 4'(((2 - y) * 4 + x) % 16)};
            got = {o_fil_first, o_fil_last, o_nz, o_ifm_first, o_shift, o_next, o_acc};
            n_cmp++;
            if (o_start !== 1'b1 || got !== exp) begin
               n_err++;
               $display("FAIL main_issue y=%0d x=%0d: start=%b fields=%h, required start=1 fields=%h", y, x, o_start, got, exp);
            end
            tick;
            sc_end = 1;
            got = {o_fil_first, o_fil_last, o_nz, o_ifm_first, o_shift, o_next, o_acc};
            n_cmp++;
            if (o_start !== 1'b0 || got !== exp || o_busy !== 1'b1) begin
               n_err++;
               $display("FAIL main_wait y=%0d x=%0d: start=%b busy=%b fields=%h, required 0/1/%h", y, x, o_start, o_busy, got, exp);
            end
            tick;
            sc_end = 0;
         end
      end
      n_cmp++;
      if (o_finish !== 1'b1 || o_start !== 1'b0 || cmd_cnt - c0 != 12) begin
         n_err++;
         $display("FAIL main_finish: finish=%b start=%b cmds=%0d, required 1/0/12", o_finish, o_start, cmd_cnt - c0);
      end
      tick;
      n_cmp++;
      if (o_finish !== 1'b0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL main_idle: finish=%b busy=%b, required 0/0", o_finish, o_busy);
      end
   endtask

   task automatic test_stride;
      logic [9:0] exp_tab [4];
      logic [4:0] exp_next [4];
      exp_tab  = '{{5'd0, 5'd0}, {5'd1, 5'd16}, {5'd3, 5'd0}, {5'd4, 5'd16}};
      exp_next = '{5'd23, 5'd23, 5'd23, 5'd0};
      set_cfg(0, 0, 0, 3, 24, 2);
      start = 1; tick; start = 0;
      for (int x = 0; x < 4; x++) begin
         n_cmp++;
         if (o_start !== 1'b1 || {o_ifm_first, o_shift} !== exp_tab[x] || o_next !== exp_next[x]) begin
            n_err++;
            $display("FAIL stride_x%0d: start=%b ifm=%0d shift=%0d next=%0d, required 1/%0d/%0d/%0d",
                     x, o_start, o_ifm_first, o_shift, o_next, exp_tab[x][9:5], exp_tab[x][4:0], exp_next[x]);
         end
         tick; sc_end = 1; tick; sc_end = 0;
      end
      n_cmp++;
      if (o_finish !== 1'b1) begin
         n_err++;
         $display("FAIL stride_finish: finish=%b, required 1", o_finish);
      end
      tick;
   endtask

   task automatic test_empty;
      int c0;
      c0 = cmd_cnt;
      set_cfg(2, 2, 1, 3, 8, 1);
      start = 1; tick; start = 0;
      n_cmp++;
      if (o_finish !== 1'b1 || o_start !== 1'b0 || o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL empty_finish: finish=%b start=%b busy=%b, required 1/0/1", o_finish, o_start, o_busy);
      end
      tick;
      n_cmp++;
      if (o_finish !== 1'b0 || o_busy !== 1'b0 || cmd_cnt != c0) begin
         n_err++;
         $display("FAIL empty_idle: finish=%b busy=%b cmds=%0d, required 0/0/0", o_finish, o_busy, cmd_cnt - c0);
      end
   endtask

   task automatic test_back_to_back;
      int c0;
      c0 = cmd_cnt;
      set_cfg(1, 1, 1, 2, 8, 0);
      start = 1; sc_end = 1; tick;
      ifm_y = 5; stride = 3; subch = 4;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (o_start !== 1'b1 || o_acc !== 4'(k) || o_shift !== 5'(k * 8) || o_fil_first !== 5'd3 || o_fil_last !== 5'd4) begin
            n_err++;
            $display("FAIL b2b_issue k=%0d: start=%b acc=%0d shift=%0d fil=%0d/%0d, required 1/%0d/%0d/3/4",
                     k, o_start, o_acc, o_shift, o_fil_first, o_fil_last, k, k * 8);
         end
         tick;
         n_cmp++;
         if (o_start !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_wait k=%0d: start=%b, required 0", k, o_start);
         end
         tick;
      end
      start = 0; sc_end = 0;
      n_cmp++;
      if (o_finish !== 1'b1 || cmd_cnt - c0 != 4) begin
         n_err++;
         $display("FAIL b2b_finish: finish=%b cmds=%0d, required 1/4", o_finish, cmd_cnt - c0);
      end
      tick;
      n_cmp++;
      if (o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: busy=%b, required 0", o_busy);
      end
   endtask

   task automatic test_reset_midrun;
      logic [32:0] got;
      int f0;
      set_cfg(2, 0, 2, 3, 8, 1);
      start = 1; tick; start = 0; tick;
      n_cmp++;
      if (o_busy !== 1'b1 || o_acc !== 4'd8) begin
         n_err++;
         $display("FAIL rst_pre_wait: busy=%b acc=%0d, required 1/8", o_busy, o_acc);
      end
      #2 rst_n = 1'b0;
      #1;
      got = {o_fil_first, o_fil_last, o_nz, o_ifm_first, o_shift, o_next, o_acc};
      n_cmp++;
      if (got !== 33'd0 || {o_start, o_finish, o_busy} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_midrun: fields=%h flags=%b, required 0/000", got, {o_start, o_finish, o_busy});
      end
      tick;
      rst_n = 1'b1;
      f0 = fin_cnt;
      tick; tick;
      n_cmp++;
      if (fin_cnt != f0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_no_finish: finishes=%0d busy=%b, required 0/0", fin_cnt - f0, o_busy);
      end
      set_cfg(3, 1, 1, 3, 8, 1);
      start = 1; tick; start = 0;
      got = {o_fil_first, o_fil_last, o_nz, o_ifm_first, o_shift, o_next, o_acc};
      n_cmp++;
      if (o_start !== 1'b1 || got !== {5'd3, 5'd5, 4'd1, 5'd0, 5'd0, 5'd7, 4'd8}) begin
         n_err++;
         $display("FAIL rst_fresh_issue: start=%b fields=%h, required 1/%h", o_start, got,
                  {5'd3, 5'd5, 4'd1, 5'd0, 5'd0, 5'd7, 4'd8});
      end
      for (int k = 0; k < 4; k++) begin
         tick; sc_end = 1; tick; sc_end = 0;
      end
      n_cmp++;
      if (o_finish !== 1'b1) begin
         n_err++;
         $display("FAIL rst_fresh_finish: finish=%b, required 1", o_finish);
      end
      tick;
   endtask

`ifdef INNER_LOOP_ABORT_EN
   task automatic test_abort;
      int c0, f0;
      set_cfg(2, 0, 2, 3, 8, 1);
      start = 1; tick; start = 0; tick;
      abort = 1; sc_end = 1; tick;
      abort = 0; sc_end = 0;
      n_cmp++;
      if (o_busy !== 1'b0 || o_start !== 1'b0 || o_finish !== 1'b0 || o_acc !== 4'd0 || o_fil_last !== 5'd0) begin
         n_err++;
         $display("FAIL abort_idle: busy=%b start=%b finish=%b acc=%0d fil_last=%0d, required all 0",
                  o_busy, o_start, o_finish, o_acc, o_fil_last);
      end
      c0 = cmd_cnt; f0 = fin_cnt;
      tick; tick; tick;
      n_cmp++;
      if (cmd_cnt != c0 || fin_cnt != f0) begin
         n_err++;
         $display("FAIL abort_quiet: cmds=%0d finishes=%0d, required 0/0", cmd_cnt - c0, fin_cnt - f0);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_main_run;
      test_stride;
      test_empty;
      test_back_to_back;
      test_reset_midrun;
`ifdef INNER_LOOP_ABORT_EN
      test_abort;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
